// File: rtl/cp_wb_rf.sv
`default_nettype none
// ============================================================================
//  Module   : cp_wb_rf
//  Purpose  : Register file with a write-back pipeline register and
//             two combinational read ports. Reads forward from the WB
//             register, and optionally from the EX input.
//             Register 0 is hard-wired to zero.
//  Config   : CP_RF_EX_BYPASS_EN -- when defined, reads forward the EX input
//             and oRF_ID_Hazard is tied 0. When undefined, a read of the
//             EX destination raises oRF_ID_Hazard.
//  Revision : 1.0 - initial release
// ============================================================================
module cp_wb_rf #(
    parameter int DATA_WIDTH     = 32,
    parameter int RF_INDEX_WIDTH = 5
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic [DATA_WIDTH-1:0]     iEX_WB_Write_RF_Data,
    input  logic [RF_INDEX_WIDTH-1:0] iEX_WB_Write_RF_Address,
    input  logic                      iEX_WB_Write_RF_Enable,
    input  logic [RF_INDEX_WIDTH-1:0] iID_RF_Read_Addr_A,
    input  logic [RF_INDEX_WIDTH-1:0] iID_RF_Read_Addr_B,
    output logic [DATA_WIDTH-1:0]     oRF_ID_Read_Data_A,
    output logic [DATA_WIDTH-1:0]     oRF_ID_Read_Data_B,
    output logic                      oRF_ID_Hazard
);

    localparam int C_DEPTH = 1 << RF_INDEX_WIDTH;

`ifdef CP_RF_EX_BYPASS_EN
    localparam logic C_EX_BYPASS = 1'b1;
`else
    localparam logic C_EX_BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]     r_wb_data;
    logic [RF_INDEX_WIDTH-1:0] r_wb_addr;
    logic                      r_wb_en;
    logic [DATA_WIDTH-1:0]     r_rf [C_DEPTH];

    // An EX request targeting register 0 is dropped here, so it never
    // enters WB and can never be forwarded or written.
    logic w_ex_valid;
    assign w_ex_valid = iEX_WB_Write_RF_Enable &&
                        (iEX_WB_Write_RF_Address != '0);

    // WB pipeline register: captures the EX request every cycle, no stall.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_wb_data <= '0;
            r_wb_addr <= '0;
            r_wb_en   <= 1'b0;
        end else begin
            r_wb_data <= iEX_WB_Write_RF_Data;
            r_wb_addr <= iEX_WB_Write_RF_Address;
            r_wb_en   <= w_ex_valid;
        end
    end

    // Register array: commits the WB entry one cycle after capture.
    // Reset clears every entry, which also drops any write still in WB.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_wb_en) begin
            r_rf[r_wb_addr] <= r_wb_data;
        end
    end

    // Per-port read select: zero register, then EX (youngest), then WB,
    // then the array. Addresses are compared on the full index width.
    function automatic logic [DATA_WIDTH-1:0] f_read(
        input logic [RF_INDEX_WIDTH-1:0] addr,
        input logic                      ex_valid,
        input logic [RF_INDEX_WIDTH-1:0] ex_addr,
        input logic [DATA_WIDTH-1:0]     ex_data,
        input logic                      wb_en,
        input logic [RF_INDEX_WIDTH-1:0] wb_addr,
        input logic [DATA_WIDTH-1:0]     wb_data,
        input logic [DATA_WIDTH-1:0]     arr_data
    );
        logic [DATA_WIDTH-1:0] v;
        if (addr == '0) begin
            v = '0;
        end else if (C_EX_BYPASS && ex_valid && (ex_addr == addr)) begin
            v = ex_data;
        end else if (wb_en && (wb_addr == addr)) begin
            v = wb_data;
        end else begin
            v = arr_data;
        end
        return v;
    endfunction

    // Port A operand.
    always_comb begin
        oRF_ID_Read_Data_A = f_read(iID_RF_Read_Addr_A, w_ex_valid,
                                    iEX_WB_Write_RF_Address,
                                    iEX_WB_Write_RF_Data,
                                    r_wb_en, r_wb_addr, r_wb_data,
                                    r_rf[iID_RF_Read_Addr_A]);
    end

    // Port B operand; same selection as port A so equal addresses agree.
    always_comb begin
        oRF_ID_Read_Data_B = f_read(iID_RF_Read_Addr_B, w_ex_valid,
                                    iEX_WB_Write_RF_Address,
                                    iEX_WB_Write_RF_Data,
                                    r_wb_en, r_wb_addr, r_wb_data,
                                    r_rf[iID_RF_Read_Addr_B]);
    end

    // Hazard: without EX forwarding, ID must wait one cycle when it reads
    // the register currently being produced in EX.
    always_comb begin
        if (C_EX_BYPASS) begin
            oRF_ID_Hazard = 1'b0;
        end else begin
            oRF_ID_Hazard = w_ex_valid &&
                            ((iEX_WB_Write_RF_Address == iID_RF_Read_Addr_A) ||
                             (iEX_WB_Write_RF_Address == iID_RF_Read_Addr_B));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp_wb_rf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp_wb_rf
//  Purpose  : Scoreboard bench for cp_wb_rf. The reference model is an
//             architectural register array: a write presented at EX becomes
//             visible to reads from the following cycle on, and (bypass build)
//             in the same cycle through EX forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp_wb_rf;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef CP_RF_EX_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          iClk = 1'b0;
    logic          iReset_n = 1'b0;
    logic [DW-1:0] ex_data = '0;
    logic [AW-1:0] ex_addr = '0;
    logic          ex_en   = 1'b0;
    logic [AW-1:0] rd_a    = '0;
    logic [AW-1:0] rd_b    = '0;
    logic [DW-1:0] dout_a;
    logic [DW-1:0] dout_b;
    logic          hazard;

    cp_wb_rf #(.DATA_WIDTH(DW), .RF_INDEX_WIDTH(AW)) dut (
        .iClk                    (iClk),
        .iReset_n                (iReset_n),
        .iEX_WB_Write_RF_Data    (ex_data),
        .iEX_WB_Write_RF_Address (ex_addr),
        .iEX_WB_Write_RF_Enable  (ex_en),
        .iID_RF_Read_Addr_A      (rd_a),
        .iID_RF_Read_Addr_B      (rd_b),
        .oRF_ID_Read_Data_A      (dout_a),
        .oRF_ID_Read_Data_B      (dout_b),
        .oRF_ID_Hazard           (hazard)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          h;
        int            tag;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [1 << AW];
    int            n_vec = 0;
    int            n_err = 0;

    // Architectural read as seen by ID in the current cycle.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
        if (addr == 0) return '0;
        if (BYPASS && ex_en && ex_addr == addr) return ex_data;
        return ref_mem[addr];
    endfunction

    function automatic logic model_hazard();
        if (BYPASS) return 1'b0;
        return ex_en && (ex_addr != 0) && (ex_addr == rd_a || ex_addr == rd_b);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    endtask

    task automatic push_expect(input int tag);
        exp_t e;
        e.a = model_read(rd_a);
        e.b = model_read(rd_b);
        e.h = model_hazard();
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Retire the EX request present at this edge into the model.
    task automatic retire();
        if (iReset_n && ex_en && ex_addr != 0) ref_mem[ex_addr] = ex_data;
    endtask

    // One clock cycle: retire previous EX, drive new inputs, queue expectation.
    task automatic cycle(input logic en, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input int tag);
        @(posedge iClk);
        retire();
        #1;
        ex_en = en; ex_addr = wa; ex_data = wd; rd_a = ra; rd_b = rb;
        push_expect(tag);
    endtask

    // Asynchronous reset pulse placed entirely between two rising edges.
    task automatic reset_pulse(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                               input int tag);
        @(posedge iClk);
        retire();
        #1;
        ex_en = 1'b0; ex_addr = '0; ex_data = '0; rd_a = ra; rd_b = rb;
        iReset_n = 1'b0;
        #1;
        iReset_n = 1'b1;
        clear_model();
        #1;
        push_expect(tag);
    endtask

    // Monitor: outputs are combinational and valid every cycle; compare on
    // the falling edge whenever an expectation is waiting.
    always @(negedge iClk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (dout_a !== e.a) begin
                n_err++;
                $display("FAIL read_a tag=%0d addr=%0d got=%h want=%h", e.tag, rd_a, dout_a, e.a);
            end
            n_vec++;
            if (dout_b !== e.b) begin
                n_err++;
                $display("FAIL read_b tag=%0d addr=%0d got=%h want=%h", e.tag, rd_b, dout_b, e.b);
            end
            n_vec++;
            if (hazard !== e.h) begin
                n_err++;
                $display("FAIL hazard tag=%0d got=%b want=%b", e.tag, hazard, e.h);
            end
        end
    end

    initial begin
        logic [AW-1:0] wa, ra, rb;
        clear_model();

        // Reset state: reads zero for arbitrary addresses, no hazard.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom), 100 + i);
        @(negedge iClk);
        #2 iReset_n = 1'b1;

        // Write r5, read it back from WB then from the array.
        cycle(1'b1, 5'd5, 32'h0000_00A5, 5'd0, 5'd0, 310);
        cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 311);
        cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 312);

        // Same-cycle read of the EX destination.
        cycle(1'b1, 5'd7, 32'h0000_0077, 5'd0, 5'd0, 320);
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 321);
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 322);
        cycle(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd0, 323);
        cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 324);

        // Back-to-back writes to r3.
        cycle(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 330);
        cycle(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 331);
        cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 332);

        // Writes to r0 are discarded.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 340);
        for (int i = 1; i <= 3; i++)
            cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 340 + i);

        // Reset while a write to r9 sits in WB.
        cycle(1'b1, 5'd9, 32'hDEAD_BEEF, 5'd0, 5'd0, 350);
        reset_pulse(5'd9, 5'd9, 351);
        cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 352);
        cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 353);

        // Both ports on r12, EX addressing r12 but not enabled.
        cycle(1'b1, 5'd12, 32'h0F0F_0F0F, 5'd0, 5'd0, 360);
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 361);
        cycle(1'b0, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd12, 362);

        // Randomized traffic, reads biased toward the recent write address.
        wa = '0;
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
            wa = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            if (i % 97 == 50)
                reset_pulse(ra, rb, 1000 + i);
            else
                cycle(1'($urandom_range(0, 1)), wa, DW'($urandom), ra, rb, 1000 + i);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge iClk);
        @(posedge iClk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp_wb_rf.md
CP_WB_RF -- requirements
Module: cp_wb_rf

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and data width in bits.
REQ-002 Parameter RF_INDEX_WIDTH, default 5: register index width; 2^RF_INDEX_WIDTH entries.
REQ-003 Port list, in order: name, direction, width, meaning.
REQ-004 iClk, in, 1: single clock, rising-edge.
REQ-005 iReset_n, in, 1: reset, asynchronous, active-low.
REQ-006 iEX_WB_Write_RF_Data, in, DATA_WIDTH: EX-stage result for write-back.
REQ-007 iEX_WB_Write_RF_Address, in, RF_INDEX_WIDTH: destination register.
REQ-008 iEX_WB_Write_RF_Enable, in, 1: destination write request.
REQ-009 iID_RF_Read_Addr_A, in, RF_INDEX_WIDTH: ID read port A address.
REQ-010 iID_RF_Read_Addr_B, in, RF_INDEX_WIDTH: ID read port B address.
REQ-011 oRF_ID_Read_Data_A, out, DATA_WIDTH: port A operand.
REQ-012 oRF_ID_Read_Data_B, out, DATA_WIDTH: port B operand.
REQ-013 oRF_ID_Hazard, out, 1: ID must stall one cycle (REQ-030).

Function
REQ-014 WB pipeline register SHALL capture data, address and enable from the EX inputs on every rising iClk; there is no stall.
REQ-015 A captured entry with enable=1 and address!=0 SHALL be written to the register file on the next rising iClk; write latency from EX input to array is 2 cycles.
REQ-016 Register 0 SHALL read 0 on both ports at all times; writes to register 0 SHALL be discarded at capture (enable forced 0).
REQ-017 Read ports SHALL be combinational: no clock between address and data.
REQ-018 Read source priority per port, highest first: EX input (REQ-019), WB register (valid, address match), array.
REQ-019 EX-input forwarding SHALL be active only when CP_RF_EX_BYPASS_EN is defined (REQ-029).
REQ-020 WB-register forwarding SHALL always be active, so a value is readable in the same cycle it sits in WB, before the array write.
REQ-021 Simultaneous matching EX and WB entries for the same address: the EX value SHALL win (youngest).
REQ-022 Ports A and B reading the same address SHALL return identical data.
REQ-023 Register 0 zeroing SHALL override every forwarding path.
REQ-024 Read addresses SHALL be compared on full RF_INDEX_WIDTH; no partial decode.

Reset
REQ-025 While iReset_n=0, the WB pipeline register SHALL hold enable=0, address=0 and data=0.
REQ-026 While iReset_n=0, all register-file entries SHALL be 0.
REQ-027 Assertion of iReset_n mid-operation SHALL discard any WB-pending write; that write SHALL not reach the array after deassertion.
REQ-028 During reset, read data SHALL be 0 for any address with EX enable=0, and oRF_ID_Hazard SHALL be 0.

Configuration
REQ-029 Macro CP_RF_EX_BYPASS_EN defined: EX-input forwarding active; oRF_ID_Hazard tied 0.
REQ-030 CP_RF_EX_BYPASS_EN undefined: no EX-input forwarding; oRF_ID_Hazard=1 when iEX_WB_Write_RF_Enable=1, EX address!=0, and EX address equals either read address; otherwise 0; combinational.

Verification
REQ-031 Reset, then write r5=0x0000_00A5 at EX; read r5 at cycles +1 and +2 -> 0xA5 from WB then from array; hazard 0 throughout.
REQ-032 Bypass build: EX writes r7=0x1234_5678 while ID reads r7 on A -> A=0x12345678 same cycle. No-bypass build: A=old r7 and hazard=1.
REQ-033 Back-to-back EX writes r3=0x11 then r3=0x22; read r3 in the cycle second write is at EX -> 0x22 (bypass) or 0x11 with hazard=1 (no bypass).
REQ-034 EX writes r0=0xFFFF_FFFF; read r0 on both ports at cycles +0..+3 -> 0 on both ports; hazard 0.
REQ-035 Write r9=0xDEAD_BEEF, pull iReset_n low asynchronously mid-cycle while the write sits in WB, release -> r9 reads 0.
REQ-036 Ports A and B both address r12 after writing 0x0F0F_0F0F; EX enable=0 with EX address=12 -> both ports 0x0F0F0F0F; hazard 0.
